mc_ctrl: RTL and testbench



---
 rtl/mc_ctrl.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle RV32I control unit.
// Latches the fetched instruction into ir and sequences it through
// IDLE/FETCH/DECODE/EXEC/MEM/WB. Memory requests are held until mem_rdy.
// Retired instructions are counted. The unit traps on an illegal opcode or
// when a memory request waits too long. TRAP is left only by reset.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   instr              memory read data, captured as the instruction in FETCH
//   mem_rdy            memory completes the current request this cycle
//   br_taken           datapath branch-condition result, sampled in EXEC
//   mem_req            memory request (instruction fetch or data access)
//   MemWrite           data store strobe (MEM of a store)
//   IRWrite            instruction capture strobe
//   RegWrite           register-file write strobe
//   PCWrite            PC update, one pulse per retired instruction
//   NPCOp              next-PC select (PC+4, PC+immB, PC+immJ, rs1+immI)
//   ALUSrc/ALUOp/EXTOp ALU operand select, ALU operation, immediate type
//   DMType             data memory access width/signedness
//   WDSel              register write-data select (ALU, memory, PC+4)
//   trap, trap_cause   sticky trap flag and cause (01 illegal, 10 timeout)
//   instret            retired-instruction count, wraps
//   state              current FSM state, for debug
module mc_ctrl #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [31:0]      instr,
   input  logic             mem_rdy,
   input  logic             br_taken,
   output logic             mem_req,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             RegWrite,
   output logic             PCWrite,
   output logic [2:0]       NPCOp,
   output logic             ALUSrc,
   output logic [4:0]       ALUOp,
   output logic [2:0]       EXTOp,
   output logic [2:0]       DMType,
   output logic [1:0]       WDSel,
   output logic             trap,
   output logic [1:0]       trap_cause,
   output logic [CNT_W-1:0] instret,
   output logic [2:0]       state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_TRAP   = 3'd6
   } state_t;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LD    = 7'b0000011;
   localparam logic [6:0] OP_ST    = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   localparam logic [4:0] ALU_NOP = 5'b00000, ALU_LUI = 5'b00001, ALU_AUIPC = 5'b00010,
                          ALU_ADD = 5'b00011, ALU_SUB = 5'b00100, ALU_SLL = 5'b00101,
                          ALU_SLT = 5'b00110, ALU_SLTU = 5'b00111, ALU_XOR = 5'b01000,
                          ALU_SRL = 5'b01001, ALU_SRA = 5'b01010, ALU_OR = 5'b01011,
                          ALU_AND = 5'b01100;

   localparam logic [2:0] EXT_NONE = 3'b000, EXT_S = 3'b001, EXT_I = 3'b010,
                          EXT_B = 3'b011, EXT_U = 3'b100, EXT_J = 3'b101;

   localparam logic [8:0] TIMEOUT_W = 9'(TIMEOUT);

   state_t      cur, nxt;
   logic [31:0] ir;
   logic [7:0]  wait_cnt;
   logic [1:0]  trap_code;
   logic        legal;
   logic        timeout_hit;
   logic [4:0]  dec_alu;
   logic        dec_src;
   logic [2:0]  dec_ext;
   logic [2:0]  dec_dm;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       is_ld, is_st, is_br;
   logic       ir_unused;

   assign opcode = ir[6:0];
   assign funct3 = ir[14:12];
   assign funct7 = ir[31:25];
   assign is_ld  = (opcode == OP_LD);
   assign is_st  = (opcode == OP_ST);
   assign is_br  = (opcode == OP_BR);
   // Register numbers and immediates belong to the datapath, not to control.
   assign ir_unused = ^{ir[24:15], ir[11:7]};

   assign state = cur;

   // The wait that would reach TIMEOUT traps, unless mem_rdy arrives in it.
   assign timeout_hit = !mem_rdy && (({1'b0, wait_cnt} + 9'd1) >= TIMEOUT_W);

   function automatic logic [4:0] alu_fn(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  return alt ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return alt ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   // NOTE: every signal assigned in an always_comb gets a default first, so no
   // path through the case statements can leave it holding a value (latch).
   always_comb begin
      legal = 1'b0;
      case (opcode)
         OP_R:     legal = (funct7 == 7'h00) ||
                           (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
         OP_I:     case (funct3)
                      3'b001:  legal = (funct7 == 7'h00);
                      3'b101:  legal = (funct7 == 7'h00) || (funct7 == 7'h20);
                      default: legal = 1'b1;
                   endcase
         OP_LD:    legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
         OP_ST:    legal = funct3 inside {3'b000, 3'b001, 3'b010};
         OP_BR:    legal = !(funct3 inside {3'b010, 3'b011});
         OP_JALR:  legal = (funct3 == 3'b000);
         OP_JAL, OP_LUI, OP_AUIPC: legal = 1'b1;
         default:  legal = 1'b0;
      endcase
   end

   always_comb begin
      dec_alu = ALU_NOP;
      dec_src = 1'b0;
      dec_ext = EXT_NONE;
      case (opcode)
         OP_R:     dec_alu = alu_fn(funct3, funct7[5]);
         // For OP-IMM only the shifts use funct7[5]; addi never becomes sub.
         OP_I:     begin dec_alu = alu_fn(funct3, funct3 == 3'b101 && funct7[5]); dec_src = 1'b1; dec_ext = EXT_I; end
         OP_LD:    begin dec_alu = ALU_ADD;   dec_src = 1'b1; dec_ext = EXT_I; end
         OP_ST:    begin dec_alu = ALU_ADD;   dec_src = 1'b1; dec_ext = EXT_S; end
         OP_BR:    begin dec_alu = ALU_SUB;   dec_ext = EXT_B; end
         OP_JAL:   dec_ext = EXT_J;
         OP_JALR:  begin dec_alu = ALU_ADD;   dec_src = 1'b1; dec_ext = EXT_I; end
         OP_LUI:   begin dec_alu = ALU_LUI;   dec_src = 1'b1; dec_ext = EXT_U; end
         OP_AUIPC: begin dec_alu = ALU_AUIPC; dec_src = 1'b1; dec_ext = EXT_U; end
         default:  ;
      endcase
   end

   always_comb begin
      case (funct3)
         3'b000:  dec_dm = 3'b011;
         3'b001:  dec_dm = 3'b001;
         3'b100:  dec_dm = 3'b100;
         3'b101:  dec_dm = 3'b010;
         default: dec_dm = 3'b000;
      endcase
   end

   always_comb begin
      nxt       = cur;
      trap_code = 2'b00;
      mem_req   = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      PCWrite   = 1'b0;
      NPCOp     = 3'b000;
      ALUSrc    = 1'b0;
      ALUOp     = ALU_NOP;
      EXTOp     = EXT_NONE;
      DMType    = 3'b000;
      WDSel     = 2'b00;
      // Decode fields hold from EXEC through WB so the datapath sees stable controls.
      if (cur == S_EXEC || cur == S_MEM || cur == S_WB) begin
         ALUOp  = dec_alu;
         ALUSrc = dec_src;
         EXTOp  = dec_ext;
      end
      case (cur)
         S_IDLE:   nxt = S_FETCH;
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_rdy) begin
               IRWrite = 1'b1;
               nxt     = S_DECODE;
            end else if (timeout_hit) begin
               nxt       = S_TRAP;
               trap_code = 2'b10;
            end
         end
         S_DECODE: begin
            if (legal) nxt = S_EXEC;
            else begin
               nxt       = S_TRAP;
               trap_code = 2'b01;
            end
         end
         S_EXEC: begin
            if (is_ld || is_st) nxt = S_MEM;
            else if (is_br) begin
               PCWrite = 1'b1;
               NPCOp   = br_taken ? 3'b001 : 3'b000;
               nxt     = S_FETCH;
            end else nxt = S_WB;
         end
         S_MEM: begin
            mem_req  = 1'b1;
            MemWrite = is_st;
            DMType   = dec_dm;
            if (mem_rdy) begin
               if (is_st) begin
                  PCWrite = 1'b1;
                  nxt     = S_FETCH;
               end else nxt = S_WB;
            end else if (timeout_hit) begin
               nxt       = S_TRAP;
               trap_code = 2'b10;
            end
         end
         S_WB: begin
            RegWrite = 1'b1;
            PCWrite  = 1'b1;
            nxt      = S_FETCH;
            if (is_ld) WDSel = 2'b01;
            else if (opcode == OP_JAL) begin
               WDSel = 2'b10;
               NPCOp = 3'b010;
            end else if (opcode == OP_JALR) begin
               WDSel = 2'b10;
               NPCOp = 3'b011;
            end
         end
         S_TRAP:   nxt = S_TRAP;
         default:  nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) cur <= S_IDLE;
      else       cur <= nxt;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ir         <= '0;
         wait_cnt   <= '0;
         instret    <= '0;
         trap       <= 1'b0;
         trap_cause <= 2'b00;
      end else begin
         if (IRWrite) ir <= instr;
         // Counting only while stalled in FETCH/MEM also clears it on entry to either.
         if ((cur == S_FETCH || cur == S_MEM) && !mem_rdy) wait_cnt <= wait_cnt + 8'd1;
         else                                                wait_cnt <= '0;
         if (PCWrite) instret <= instret + CNT_W'(1);
         if (nxt == S_TRAP && cur != S_TRAP) begin
            trap       <= 1'b1;
            trap_cause <= trap_code;
         end
      end
   end

endmodule

// File: tb/tb_mc_ctrl.sv
module tb_mc_ctrl;

   localparam int TIMEOUT_P = 4;
   localparam int CNT_W_P   = 4;
   localparam int CNT_MASK  = (1 << CNT_W_P) - 1;

   localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_EXEC = 3,
                  ST_MEM = 4, ST_WB = 5, ST_TRAP = 6;

   logic               clk = 1'b0;
   logic               rstn = 1'b0;
   logic [31:0]        instr = '0;
   logic               mem_rdy = 1'b0;
   logic               br_taken = 1'b0;
   logic               mem_req, MemWrite, IRWrite, RegWrite, PCWrite;
   logic [2:0]         NPCOp;
   logic               ALUSrc;
   logic [4:0]         ALUOp;
   logic [2:0]         EXTOp, DMType;
   logic [1:0]         WDSel;
   logic               trap;
   logic [1:0]         trap_cause;
   logic [CNT_W_P-1:0] instret;
   logic [2:0]         state;

   always #5 clk = ~clk;

   mc_ctrl #(.TIMEOUT(TIMEOUT_P), .CNT_W(CNT_W_P)) dut (
      .clk(clk), .rstn(rstn), .instr(instr), .mem_rdy(mem_rdy), .br_taken(br_taken),
      .mem_req(mem_req), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
      .PCWrite(PCWrite), .NPCOp(NPCOp), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .EXTOp(EXTOp),
      .DMType(DMType), .WDSel(WDSel), .trap(trap), .trap_cause(trap_cause),
      .instret(instret), .state(state)
   );

   int n_checks = 0;
   int n_errors = 0;
   int model_instret = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef enum int {K_R, K_I, K_LD, K_ST, K_BR, K_JAL, K_JALR, K_LUI, K_AUIPC, K_ILL} kind_t;

   function automatic kind_t classify(input logic [31:0] ins);
      logic [2:0] f3 = ins[14:12];
      logic [6:0] f7 = ins[31:25];
      case (ins[6:0])
         7'h33: if (f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5))) return K_R;
         7'h13: if ((f3 != 1 && f3 != 5) || f7 == 0 || (f3 == 5 && f7 == 7'h20)) return K_I;
         7'h03: if (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) return K_LD;
         7'h23: if (f3 <= 2) return K_ST;
         7'h63: if (f3 != 2 && f3 != 3) return K_BR;
         7'h6F: return K_JAL;
         7'h67: if (f3 == 0) return K_JALR;
         7'h37: return K_LUI;
         7'h17: return K_AUIPC;
         default: ;
      endcase
      return K_ILL;
   endfunction

   // One expected cycle: state plus strobes, and the jump/write-data selects
   // that matter in the retiring cycle.
   typedef struct {
      int st;
      bit rdy, mreq, irw, memw, regw, pcw;
      int npc, wds;
   } cyc_t;

   function automatic cyc_t mk(int st, bit rdy, bit mreq, bit irw, bit memw,
                               bit regw, bit pcw, int npc, int wds);
      cyc_t c;
      c.st = st; c.rdy = rdy; c.mreq = mreq; c.irw = irw; c.memw = memw;
      c.regw = regw; c.pcw = pcw; c.npc = npc; c.wds = wds;
      return c;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0;
      mem_rdy = 1'b1;
      #1;
      check("reset.state", state, ST_IDLE);
      check("reset.instret", instret, 0);
      check("reset.trap", trap, 0);
      @(negedge clk);
      rstn = 1'b1;
      #1;
      check("idle.state", state, ST_IDLE);
      check("idle.outputs", {mem_req, MemWrite, IRWrite, RegWrite, PCWrite, NPCOp, ALUSrc,
                             ALUOp, EXTOp, DMType, WDSel, trap, trap_cause}, 0);
      model_instret = 0;
   endtask

   // Runs one instruction starting in FETCH: fs/ms stall cycles in FETCH/MEM,
   // br the branch outcome. When chk is set, the decode fields are compared.
   task automatic run_one(input logic [31:0] ins, input int fs, input int ms, input bit br,
                          input bit chk, input logic [4:0] e_alu, input logic e_src,
                          input logic [2:0] e_ext, input logic [2:0] e_dm);
      cyc_t  q[$];
      kind_t k = classify(ins);
      int    cause = 0;
      bit    ldst = (k == K_LD || k == K_ST);
      bit    stv  = (k == K_ST);
      bit    jmp  = (k == K_JAL || k == K_JALR);
      for (int i = 0; i < fs && i < TIMEOUT_P; i++) q.push_back(mk(ST_FETCH, 0, 1, 0, 0, 0, 0, 0, 0));
      if (fs >= TIMEOUT_P) cause = 2;
      else begin
         q.push_back(mk(ST_FETCH, 1, 1, 1, 0, 0, 0, 0, 0));
         q.push_back(mk(ST_DECODE, 1'($urandom), 0, 0, 0, 0, 0, 0, 0));
         if (k == K_ILL) cause = 1;
         else begin
            q.push_back(mk(ST_EXEC, 1'($urandom), 0, 0, 0, 0, k == K_BR, br ? 1 : 0, 0));
            if (ldst) begin
               for (int i = 0; i < ms && i < TIMEOUT_P; i++) q.push_back(mk(ST_MEM, 0, 1, 0, stv, 0, 0, 0, 0));
               if (ms >= TIMEOUT_P) cause = 2;
               else begin
                  q.push_back(mk(ST_MEM, 1, 1, 0, stv, 0, stv, 0, 0));
                  if (k == K_LD) q.push_back(mk(ST_WB, 1'($urandom), 0, 0, 0, 1, 1, 0, 1));
               end
            end else if (k != K_BR) begin
               q.push_back(mk(ST_WB, 1'($urandom), 0, 0, 0, 1, 1,
                              (k == K_JAL) ? 2 : (k == K_JALR) ? 3 : 0, jmp ? 2 : 0));
            end
         end
      end
      foreach (q[i]) begin
         string t = $sformatf("%08h c%0d", ins, i);
         @(negedge clk);
         instr = ins;
         mem_rdy = q[i].rdy;
         br_taken = br;
         #1;
         check({t, " state"}, state, q[i].st);
         if (i == 0) check({t, " instret"}, instret, model_instret & CNT_MASK);
         check({t, " mem_req"}, mem_req, q[i].mreq);
         check({t, " IRWrite"}, IRWrite, q[i].irw);
         check({t, " MemWrite"}, MemWrite, q[i].memw);
         check({t, " RegWrite"}, RegWrite, q[i].regw);
         check({t, " PCWrite"}, PCWrite, q[i].pcw);
         check({t, " trap"}, trap, 0);
         if (q[i].pcw) check({t, " NPCOp"}, NPCOp, q[i].npc);
         if (q[i].regw) check({t, " WDSel"}, WDSel, q[i].wds);
         if (chk && q[i].st >= ST_EXEC) begin
            check({t, " ALUOp"}, ALUOp, e_alu);
            check({t, " ALUSrc"}, ALUSrc, e_src);
            check({t, " EXTOp"}, EXTOp, e_ext);
         end
         if (chk && q[i].st == ST_MEM) check({t, " DMType"}, DMType, e_dm);
         if (q[i].pcw) model_instret++;
      end
      if (cause != 0) begin
         @(negedge clk);
         mem_rdy = 1'($urandom);
         #1;
         check("trap.state", state, ST_TRAP);
         check("trap.flag", trap, 1);
         check("trap.cause", trap_cause, cause);
         check("trap.strobes", {mem_req, MemWrite, IRWrite, RegWrite, PCWrite}, 0);
         check("trap.instret", instret, model_instret & CNT_MASK);
         do_reset();
      end
   endtask

   function automatic logic [31:0] rand_instr(input int sel);
      logic [31:0] r = $urandom;
      logic [2:0]  f3 = r[14:12];
      logic [6:0]  hi;
      case (sel)
         0: begin
            hi = ((f3 == 0 || f3 == 5) && r[30]) ? 7'h20 : 7'h00;
            return {hi, r[24:15], f3, r[11:7], 7'h33};
         end
         1: begin
            hi = (f3 == 1) ? 7'h00 : (f3 == 5) ? (r[30] ? 7'h20 : 7'h00) : r[31:25];
            return {hi, r[24:15], f3, r[11:7], 7'h13};
         end
         2: begin
            f3 = (f3 == 3 || f3 == 6 || f3 == 7) ? 3'b100 : f3;
            return {r[31:15], f3, r[11:7], 7'h03};
         end
         3: return {r[31:15], 3'(r[13:12] == 2'b11 ? 2'b10 : r[13:12]), r[11:7], 7'h23};
         4: begin
            f3 = (f3 == 2 || f3 == 3) ? 3'b000 : f3;
            return {r[31:15], f3, r[11:7], 7'h63};
         end
         5: return {r[31:7], 7'h6F};
         6: return {r[31:15], 3'b000, r[11:7], 7'h67};
         7: return {r[31:7], 7'h37};
         8: return {r[31:7], 7'h17};
         default: return r[0] ? {r[31:7], 7'h0B} : {r[31:15], 3'b001, r[11:7], 7'h67};
      endcase
   endfunction

   typedef struct {
      logic [31:0] ins;
      bit          chk;
      logic [4:0]  alu;
      logic        src;
      logic [2:0]  ext;
      logic [2:0]  dm;
   } vec_t;

   vec_t vecs[$];

   initial begin
      vecs.push_back('{32'h002081B3, 1, 5'b00011, 1'b0, 3'b000, 3'b000}); // add
      vecs.push_back('{32'h402081B3, 1, 5'b00100, 1'b0, 3'b000, 3'b000}); // sub
      vecs.push_back('{32'h407352B3, 1, 5'b01010, 1'b0, 3'b000, 3'b000}); // sra
      vecs.push_back('{32'h003130B3, 1, 5'b00111, 1'b0, 3'b000, 3'b000}); // sltu
      vecs.push_back('{32'h003120B3, 1, 5'b00110, 1'b0, 3'b000, 3'b000}); // slt
      vecs.push_back('{32'h003110B3, 1, 5'b00101, 1'b0, 3'b000, 3'b000}); // sll
      vecs.push_back('{32'h003140B3, 1, 5'b01000, 1'b0, 3'b000, 3'b000}); // xor
      vecs.push_back('{32'h003150B3, 1, 5'b01001, 1'b0, 3'b000, 3'b000}); // srl
      vecs.push_back('{32'h003160B3, 1, 5'b01011, 1'b0, 3'b000, 3'b000}); // or
      vecs.push_back('{32'h00500093, 1, 5'b00011, 1'b1, 3'b010, 3'b000}); // addi
      vecs.push_back('{32'h40315113, 1, 5'b01010, 1'b1, 3'b010, 3'b000}); // srai
      vecs.push_back('{32'h00111113, 1, 5'b00101, 1'b1, 3'b010, 3'b000}); // slli
      vecs.push_back('{32'h0FF17093, 1, 5'b01100, 1'b1, 3'b010, 3'b000}); // andi
      vecs.push_back('{32'h123452B7, 1, 5'b00001, 1'b1, 3'b100, 3'b000}); // lui
      vecs.push_back('{32'h00001297, 1, 5'b00010, 1'b1, 3'b100, 3'b000}); // auipc
      vecs.push_back('{32'h00812303, 1, 5'b00011, 1'b1, 3'b010, 3'b000}); // lw
      vecs.push_back('{32'h00011303, 1, 5'b00011, 1'b1, 3'b010, 3'b001}); // lh
      vecs.push_back('{32'h00015303, 1, 5'b00011, 1'b1, 3'b010, 3'b010}); // lhu
      vecs.push_back('{32'h00010303, 1, 5'b00011, 1'b1, 3'b010, 3'b011}); // lb
      vecs.push_back('{32'h00014303, 1, 5'b00011, 1'b1, 3'b010, 3'b100}); // lbu
      vecs.push_back('{32'h00712223, 1, 5'b00011, 1'b1, 3'b001, 3'b000}); // sw
      vecs.push_back('{32'h00710023, 1, 5'b00011, 1'b1, 3'b001, 3'b011}); // sb
      vecs.push_back('{32'h000000EF, 0, 5'b00000, 1'b0, 3'b000, 3'b000}); // jal
      vecs.push_back('{32'h403110B3, 0, 5'b00000, 1'b0, 3'b000, 3'b000}); // bad R funct7
      vecs.push_back('{32'h000010E7, 0, 5'b00000, 1'b0, 3'b000, 3'b000}); // jalr funct3 001
      vecs.push_back('{32'h00013303, 0, 5'b00000, 1'b0, 3'b000, 3'b000}); // load funct3 011
      vecs.push_back('{32'h00713023, 0, 5'b00000, 1'b0, 3'b000, 3'b000}); // store funct3 011
      vecs.push_back('{32'h00002063, 0, 5'b00000, 1'b0, 3'b000, 3'b000}); // branch funct3 010

      do_reset();

      foreach (vecs[i])
         run_one(vecs[i].ins, 0, 0, 1'b0, vecs[i].chk, vecs[i].alu, vecs[i].src, vecs[i].ext, vecs[i].dm);

      // lbu with three MEM stall cycles: eight cycles in total
      run_one(32'h00014303, 0, 3, 1'b0, 1, 5'b00011, 1'b1, 3'b010, 3'b100);
      // beq taken, then not taken
      run_one(32'h00208063, 0, 0, 1'b1, 0, '0, 1'b0, '0, '0);
      run_one(32'h00208063, 0, 0, 1'b0, 0, '0, 1'b0, '0, '0);
      // jalr, then an all-ones word traps as illegal
      run_one(32'h000100E7, 0, 0, 1'b0, 1, 5'b00011, 1'b1, 3'b010, 3'b000);
      run_one(32'h00000000, 0, 0, 1'b0, 0, '0, 1'b0, '0, '0);
      run_one(32'hFFFFFFFF, 0, 0, 1'b0, 0, '0, 1'b0, '0, '0);
      // fetch timeout, then mem_rdy in the last allowed wait cycle
      run_one(32'h002081B3, TIMEOUT_P, 0, 1'b0, 0, '0, 1'b0, '0, '0);
      run_one(32'h002081B3, TIMEOUT_P - 1, 0, 1'b0, 0, '0, 1'b0, '0, '0);
      // store timeout in MEM
      run_one(32'h00712223, 1, TIMEOUT_P, 1'b0, 0, '0, 1'b0, '0, '0);

      // 17 retirements wrap a 4-bit counter to 1
      do_reset();
      for (int i = 0; i < 17; i++) run_one(32'h002081B3, 0, 0, 1'b0, 0, '0, 1'b0, '0, '0);
      @(negedge clk);
      #1;
      check("wrap.instret", instret, 1);
      do_reset();

      // reset pulse during MEM of a store
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         instr = 32'h00712223;
         mem_rdy = (i < 3);
         #1;
         check($sformatf("midrst c%0d state", i), state, i + 1);
      end
      check("midrst MemWrite before", MemWrite, 1);
      #2;
      rstn = 1'b0;
      #1;
      check("midrst state", state, ST_IDLE);
      check("midrst strobes", {MemWrite, PCWrite, RegWrite}, 0);
      @(negedge clk);
      rstn = 1'b1;
      mem_rdy = 1'b1;
      #1;
      check("midrst release state", state, ST_IDLE);
      check("midrst release MemWrite", MemWrite, 0);
      check("midrst release instret", instret, 0);
      model_instret = 0;
      run_one(32'h002081B3, 0, 0, 1'b0, 1, 5'b00011, 1'b0, 3'b000, 3'b000);

      // randomized instruction stream with random stalls
      for (int n = 0; n < 150; n++) begin
         int sel = $urandom_range(0, 19);
         int fs  = ($urandom_range(0, 19) == 0) ? TIMEOUT_P : $urandom_range(0, 2);
         int ms  = ($urandom_range(0, 19) == 0) ? TIMEOUT_P : $urandom_range(0, 2);
         if (sel >= 10) sel = sel - 10;
         run_one(rand_instr(sel), fs, ms, 1'($urandom), 0, '0, 1'b0, '0, '0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
